thcattus_uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmitter AXI-Stream input among NUM_SRC requesters (debug console, status reporter, etc.). It locks the grant for a whole message, delimited by tlast, so bytes from different sources never interleave on the wire. A watchdog releases the lock if the granted source stalls mid-message. It sits directly in front of the UART TX block, whose tready is high only when the transmitter is idle.

---
 rtl/thcattus_uart_tx_arbiter_if.sv | 34 +++
 rtl/thcattus_uart_tx_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/thcattus_uart_tx_arbiter_if.sv
// AXI-Stream bundle between NUM_SRC requesters, the TX arbiter and the UART TX,
// plus the arbiter's grant/status outputs.
interface thcattus_uart_tx_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int ID_W = $clog2(NUM_SRC);
  localparam int DW   = DATA_WIDTH * 8;

  logic [NUM_SRC-1:0]    s_axis_tvalid;
  logic [NUM_SRC-1:0]    s_axis_tready;
  logic [NUM_SRC*DW-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]    s_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DW-1:0]         m_axis_tdata;
  logic                  grant_active;
  logic [ID_W-1:0]       grant_id;
  logic                  timeout_pulse;

  // arbiter side: masters the stream toward the UART TX
  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata,
           grant_active, grant_id, timeout_pulse
  );

  // environment side: requesters, UART TX and status observers
  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata,
           grant_active, grant_id, timeout_pulse
  );
endinterface

// File: rtl/thcattus_uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART TX stream among NUM_SRC
// sources, with a watchdog that frees a lock whose source stalls mid-message.
module thcattus_uart_tx_arbiter_lane #(
  parameter int DW = 32
) (
  input  logic          sel,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  input  logic [DW-1:0] s_tdata,
  input  logic          m_tready,
  output logic          s_tready,
  output logic          q_tvalid,
  output logic          q_tlast,
  output logic [DW-1:0] q_tdata
);
  // masked per-source view; the top OR-reduces these into the single output
  assign s_tready = sel & m_tready;
  assign q_tvalid = sel & s_tvalid;
  assign q_tlast  = sel & s_tlast;
  assign q_tdata  = sel ? s_tdata : '0;
endmodule

module thcattus_uart_tx_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WIDTH   = 4,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic                        axis_aclk,
  input  logic                        axis_areset,
  thcattus_uart_tx_arbiter_if.master  bus
);
  localparam int ID_W  = $clog2(NUM_SRC);
  localparam int DW    = DATA_WIDTH * 8;
  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                     state, state_nxt;
  logic [ID_W-1:0]            grant_id, last_grant, win;
  logic                       win_vld;
  logic [CNT_W-1:0]           wd_cnt;
  logic                       timeout_pulse;
  logic [NUM_SRC-1:0]         sel, q_tvalid, q_tlast;
  logic [NUM_SRC-1:0][DW-1:0] s_data, q_tdata;
  logic [DW-1:0]              m_data;
  logic                       m_tvalid, g_tlast, beat, end_msg, wd_hit;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
    assign s_data[k] = bus.s_axis_tdata[k*DW +: DW];
    assign sel[k]    = (state == LOCKED) && (grant_id == ID_W'(k));
    thcattus_uart_tx_arbiter_lane #(.DW(DW)) u_lane (
      .sel      (sel[k]),
      .s_tvalid (bus.s_axis_tvalid[k]),
      .s_tlast  (bus.s_axis_tlast[k]),
      .s_tdata  (s_data[k]),
      .m_tready (bus.m_axis_tready),
      .s_tready (bus.s_axis_tready[k]),
      .q_tvalid (q_tvalid[k]),
      .q_tlast  (q_tlast[k]),
      .q_tdata  (q_tdata[k])
    );
  end

  always_comb begin
    m_data = '0;
    for (int k = 0; k < NUM_SRC; k++) m_data = m_data | q_tdata[k];
  end

  assign m_tvalid = |q_tvalid;
  assign g_tlast  = |q_tlast;
  assign beat     = m_tvalid & bus.m_axis_tready;
  assign end_msg  = beat & g_tlast;
  // a beat in the limit cycle always wins over the watchdog
  assign wd_hit   = (LOCK_TIMEOUT != 0) && (state == LOCKED) && (wd_cnt == CNT_LIM) && !beat;

  // round-robin search starting just above the last released source
  always_comb begin
    logic [ID_W:0] idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = {1'b0, last_grant} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_SRC)) idx = idx - (ID_W+1)'(NUM_SRC);
      if (!win_vld && bus.s_axis_tvalid[idx[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win     = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld)          state_nxt = LOCKED;
      LOCKED:  if (end_msg || wd_hit) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state         <= IDLE;
      grant_id      <= '0;
      last_grant    <= ID_W'(NUM_SRC - 1);
      wd_cnt        <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      timeout_pulse <= wd_hit;
      if (state == IDLE && win_vld) grant_id <= win;
      if (state == LOCKED && state_nxt == IDLE) last_grant <= grant_id;
      if (state == IDLE || beat)    wd_cnt <= '0;
      else if (wd_cnt != '1)        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign bus.m_axis_tvalid = m_tvalid;
  assign bus.m_axis_tdata  = m_data;
  assign bus.grant_active  = (state == LOCKED);
  assign bus.grant_id      = grant_id;
  assign bus.timeout_pulse = timeout_pulse;
endmodule
